// File: rtl/n_clic_ext.sv
// Core-local vectored interrupt controller: registered arbiter plus EPC/threshold stack.
// Define NCLIC_TAIL_CHAIN_EN to chain a pending winner directly on interrupt return.
package n_clic_pkg;
  typedef enum logic [2:0] {
    CSR_NONE = 3'd0,
    CSR_RW   = 3'd1,
    CSR_RS   = 3'd2,
    CSR_RC   = 3'd3,
    CSR_RWI  = 3'd5,
    CSR_RSI  = 3'd6,
    CSR_RCI  = 3'd7
  } csr_op_t;
  localparam logic PC_NORMAL    = 1'b0;
  localparam logic PC_INTERRUPT = 1'b1;
endpackage

module n_clic_ext
  import n_clic_pkg::*;
#(
  parameter int          VecNum         = 8,
  parameter int          ExtNum         = 4,
  parameter int          PrioWidth      = 3,
  parameter int          AddrWidth      = 12,
  parameter logic [11:0] VecCsrBase     = 12'hB00,
  parameter logic [11:0] EntryCsrBase   = 12'hB20,
  parameter logic [11:0] ThreshAddr     = 12'h347,
  parameter logic [11:0] StackDepthAddr = 12'h350,
  parameter logic [11:0] MStatusAddr    = 12'h300
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 csr_enable,
  input  logic [11:0]          csr_addr,
  input  csr_op_t              csr_op,
  input  logic [4:0]           rs1_zimm,
  input  logic [31:0]          rs1_data,
  input  logic [AddrWidth-1:0] pc_in,
  input  logic [ExtNum-1:0]    ext_irq,
  output logic [31:0]          csr_out,
  output logic [AddrWidth-1:0] int_addr,
  output logic                 pc_interrupt_sel,
  output logic                 interrupt_out,
  output logic [PrioWidth:0]   level_out,
  output logic                 stack_err
);
  localparam int IdxW  = $clog2(VecNum);
  localparam int Depth = 2 ** PrioWidth;
  localparam int EW    = PrioWidth + 3;
  localparam int LW    = PrioWidth + 1;
  localparam int VW    = AddrWidth - 2;

  typedef struct packed {
    logic                 valid;
    logic [IdxW-1:0]      idx;
    logic [PrioWidth-1:0] prio;
    logic [VW-1:0]        vec;
  } win_t;

  logic [EW-1:0]        entry_q [VecNum];
  logic [EW-1:0]        entry_d [VecNum];
  logic [VW-1:0]        vec_q [VecNum];
  logic [VW-1:0]        vec_d [VecNum];
  logic [AddrWidth-1:0] stk_addr_q [Depth];
  logic [AddrWidth-1:0] stk_addr_d [Depth];
  logic [PrioWidth-1:0] stk_prio_q [Depth];
  logic [PrioWidth-1:0] stk_prio_d [Depth];
  logic [PrioWidth-1:0] thresh_q, thresh_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 mie_q, mie_d;
  logic                 err_q, err_d;
  logic [ExtNum-1:0]    sync1_q, sync1_d;
  logic [ExtNum-1:0]    sync2_q, sync2_d;
  logic [ExtNum-1:0]    sync3_q, sync3_d;
  win_t                 win_q, win_d, arb;

  logic [31:0]          wdata;
  logic [11:0]          vec_off, ent_off;
  logic                 vec_hit, ent_hit;
  logic [IdxW-1:0]      vec_idx, ent_idx;
  logic [PrioWidth-1:0] top_idx, push_idx;
  logic                 ret, win_live, full, empty;
  logic                 tail, pop_req, take_req, do_pop, do_take;

  function automatic logic [31:0] csr_upd(
    input logic [31:0] old,
    input csr_op_t     op,
    input logic [31:0] wd
  );
    case (op)
      CSR_RW, CSR_RWI: csr_upd = wd;
      CSR_RS, CSR_RSI: csr_upd = old | wd;
      CSR_RC, CSR_RCI: csr_upd = old & ~wd;
      default:         csr_upd = old;
    endcase
  endfunction

  always_comb begin
    wdata = rs1_data;
    if (csr_op inside {CSR_RWI, CSR_RSI, CSR_RCI})
      wdata = {27'd0, rs1_zimm};
    vec_off  = csr_addr - VecCsrBase;
    ent_off  = csr_addr - EntryCsrBase;
    vec_hit  = vec_off < 12'(VecNum);
    ent_hit  = ent_off < 12'(VecNum);
    vec_idx  = vec_off[IdxW-1:0];
    ent_idx  = ent_off[IdxW-1:0];
    top_idx  = PrioWidth'(level_q - LW'(1));
    push_idx = PrioWidth'(level_q);
  end

  // Ascending scan with >= makes the highest index win on equal priority.
  always_comb begin
    arb = '0;
    for (int i = 0; i < VecNum; i++) begin
      if (entry_q[i][1] && entry_q[i][0] &&
          entry_q[i][EW-2:2] >= thresh_q &&
          (!arb.valid || entry_q[i][EW-2:2] >= arb.prio)) begin
        arb.valid = 1'b1;
        arb.idx   = IdxW'(i);
        arb.prio  = entry_q[i][EW-2:2];
        arb.vec   = vec_q[i];
      end
    end
  end

  always_comb begin
    ret      = &pc_in;
    win_live = win_q.valid && entry_q[win_q.idx][1] &&
               entry_q[win_q.idx][0];
    full     = level_q == LW'(Depth);
    empty    = level_q == '0;
`ifdef NCLIC_TAIL_CHAIN_EN
    tail     = ret && mie_q && win_live && win_q.prio >= thresh_q;
`else
    tail     = 1'b0;
`endif
    pop_req  = ret && !tail;
    take_req = !ret && mie_q && win_live && win_q.prio > thresh_q;
    do_pop   = pop_req && !empty;
    do_take  = take_req && !full;
  end

  always_comb begin
    int_addr         = pc_in;
    pc_interrupt_sel = PC_NORMAL;
    if (do_take || tail) begin
      int_addr         = {win_q.vec, 2'b00};
      pc_interrupt_sel = PC_INTERRUPT;
    end else if (do_pop) begin
      int_addr         = stk_addr_q[top_idx];
      pc_interrupt_sel = PC_INTERRUPT;
    end
    interrupt_out = do_take || tail;
    level_out     = level_q;
    stack_err     = err_q;
  end

  always_comb begin
    csr_out = '0;
    if (csr_addr == ThreshAddr)
      csr_out = 32'(thresh_q);
    else if (csr_addr == StackDepthAddr)
      csr_out = 32'(level_q);
    else if (csr_addr == MStatusAddr)
      csr_out = {28'd0, mie_q, 3'd0};
    else if (vec_hit)
      csr_out = 32'(vec_q[vec_idx]);
    else if (ent_hit)
      csr_out = 32'(entry_q[ent_idx]);
  end

  always_comb begin
    entry_d    = entry_q;
    vec_d      = vec_q;
    stk_addr_d = stk_addr_q;
    stk_prio_d = stk_prio_q;
    thresh_d   = thresh_q;
    level_d    = level_q;
    mie_d      = mie_q;
    err_d      = err_q;
    win_d      = arb;
    sync1_d    = ext_irq;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;
    if (csr_enable) begin
      if (csr_addr == ThreshAddr)
        thresh_d = PrioWidth'(csr_upd(32'(thresh_q), csr_op, wdata));
      if (csr_addr == MStatusAddr)
        mie_d = |(csr_upd({28'd0, mie_q, 3'd0}, csr_op, wdata) & 32'h8);
      if (vec_hit)
        vec_d[vec_idx] = VW'(csr_upd(32'(vec_q[vec_idx]), csr_op, wdata));
      if (ent_hit)
        entry_d[ent_idx] = EW'(csr_upd(32'(entry_q[ent_idx]), csr_op, wdata));
    end
    if (do_take) begin
      stk_addr_d[push_idx] = pc_in;
      stk_prio_d[push_idx] = thresh_q;
      level_d  = level_q + LW'(1);
      thresh_d = win_q.prio;
    end
    if (do_pop) begin
      level_d  = level_q - LW'(1);
      thresh_d = stk_prio_q[top_idx];
    end
    if (do_take || tail) begin
      entry_d[win_q.idx][0] = 1'b0;
      win_d = '0;
    end
    if ((pop_req && empty) || (take_req && full))
      err_d = 1'b1;
    // Hardware pend lands last so it beats a same-cycle clear.
    for (int i = 0; i < ExtNum; i++) begin
      if (entry_q[i][EW-1] ? (sync2_q[i] && !sync3_q[i]) : sync2_q[i])
        entry_d[i][0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < VecNum; i++) begin
        entry_q[i] <= '0;
        vec_q[i]   <= '0;
      end
      for (int i = 0; i < Depth; i++) begin
        stk_addr_q[i] <= '0;
        stk_prio_q[i] <= '0;
      end
      thresh_q <= '0;
      level_q  <= '0;
      mie_q    <= 1'b0;
      err_q    <= 1'b0;
      win_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
    end else begin
      entry_q    <= entry_d;
      vec_q      <= vec_d;
      stk_addr_q <= stk_addr_d;
      stk_prio_q <= stk_prio_d;
      thresh_q   <= thresh_d;
      level_q    <= level_d;
      mie_q      <= mie_d;
      err_q      <= err_d;
      win_q      <= win_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
    end
  end
endmodule

// File: tb/tb_n_clic_ext.sv
// Directed bench for n_clic_ext: take, tail/return, threshold, ext lines, stack error, reset.
// Expected values follow the NCLIC_TAIL_CHAIN_EN setting of the build.
module tb_n_clic_ext;
  import n_clic_pkg::*;

  localparam logic [11:0] PCN = 12'h100;
  localparam logic [11:0] TH  = 12'h347;
  localparam logic [11:0] SD  = 12'h350;
  localparam logic [11:0] MS  = 12'h300;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        csr_enable = 1'b0;
  logic [11:0] csr_addr = 12'h0;
  csr_op_t     csr_op = CSR_NONE;
  logic [4:0]  rs1_zimm = 5'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [11:0] pc_in = PCN;
  logic [3:0]  ext_irq = 4'd0;
  logic [31:0] csr_out;
  logic [11:0] int_addr;
  logic        pc_interrupt_sel;
  logic        interrupt_out;
  logic [3:0]  level_out;
  logic        stack_err;

  int tests = 0;
  int fails = 0;

  n_clic_ext dut (
    .clk(clk), .reset(reset), .csr_enable(csr_enable),
    .csr_addr(csr_addr), .csr_op(csr_op), .rs1_zimm(rs1_zimm),
    .rs1_data(rs1_data), .pc_in(pc_in), .ext_irq(ext_irq),
    .csr_out(csr_out), .int_addr(int_addr),
    .pc_interrupt_sel(pc_interrupt_sel),
    .interrupt_out(interrupt_out), .level_out(level_out),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic csr_wr(input logic [11:0] a, input csr_op_t op,
                        input logic [31:0] d);
    csr_enable = 1'b1;
    csr_addr   = a;
    csr_op     = op;
    rs1_data   = d;
    rs1_zimm   = d[4:0];
    tick();
    csr_enable = 1'b0;
    csr_op     = CSR_NONE;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #1;
    d = csr_out;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if (int_addr !== PCN || pc_interrupt_sel !== 1'b0) begin
      fails++;
      $display("FAIL rst_pc: got %h/%b want %h/0", int_addr, pc_interrupt_sel, PCN);
    end
    tests++;
    if (interrupt_out !== 1'b0 || level_out !== 4'd0 || stack_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_flags: got %b/%h/%b want 0/0/0", interrupt_out, level_out, stack_err);
    end
    csr_rd(TH, d);
    tests++;
    if (d !== 32'd0) begin
      fails++;
      $display("FAIL rst_thresh: got %h want 0", d);
    end
  endtask

  task automatic test_take();
    logic [31:0] d;
    for (int i = 0; i < 8; i++)
      csr_wr(12'hB00 + 12'(i), CSR_RW, 32'h100 + 32'(i));
    csr_rd(12'hB03, d);
    tests++;
    if (d !== 32'h103) begin
      fails++;
      $display("FAIL vec_rd: got %h want 103", d);
    end
    csr_wr(12'hB22, CSR_RW, 32'h0F);
    csr_wr(12'hB25, CSR_RW, 32'h0F);
    csr_wr(MS, CSR_RSI, 32'h8);
    #1;
    tests++;
    if (interrupt_out !== 1'b1 || int_addr !== 12'h414 || pc_interrupt_sel !== 1'b1) begin
      fails++;
      $display("FAIL take5: got %b/%h/%b want 1/414/1", interrupt_out, int_addr, pc_interrupt_sel);
    end
    tick();
    #1;
    tests++;
    if (level_out !== 4'd1 || interrupt_out !== 1'b0) begin
      fails++;
      $display("FAIL take5_lvl: got %h/%b want 1/0", level_out, interrupt_out);
    end
    csr_rd(TH, d);
    tests++;
    if (d !== 32'd3) begin
      fails++;
      $display("FAIL take5_th: got %h want 3", d);
    end
    csr_rd(12'hB25, d);
    tests++;
    if (d !== 32'h0E) begin
      fails++;
      $display("FAIL pend5: got %h want 0e", d);
    end
    csr_rd(12'hB22, d);
    tests++;
    if (d !== 32'h0F) begin
      fails++;
      $display("FAIL pend2: got %h want 0f", d);
    end
  endtask

  task automatic test_return();
    logic [31:0] d;
    tick();
    #1;
    tests++;
    if (interrupt_out !== 1'b0) begin
      fails++;
      $display("FAIL eq_prio_hold: got %b want 0", interrupt_out);
    end
    pc_in = 12'hFFF;
    #1;
`ifdef NCLIC_TAIL_CHAIN_EN
    tests++;
    if (interrupt_out !== 1'b1 || int_addr !== 12'h408 || pc_interrupt_sel !== 1'b1) begin
      fails++;
      $display("FAIL tail: got %b/%h/%b want 1/408/1", interrupt_out, int_addr, pc_interrupt_sel);
    end
    tick();
    pc_in = PCN;
    #1;
    tests++;
    if (level_out !== 4'd1) begin
      fails++;
      $display("FAIL tail_lvl: got %h want 1", level_out);
    end
`else
    tests++;
    if (interrupt_out !== 1'b0 || int_addr !== PCN || pc_interrupt_sel !== 1'b1) begin
      fails++;
      $display("FAIL pop: got %b/%h/%b want 0/%h/1", interrupt_out, int_addr, pc_interrupt_sel, PCN);
    end
    tick();
    pc_in = PCN;
    #1;
    tests++;
    if (level_out !== 4'd0 || interrupt_out !== 1'b1 || int_addr !== 12'h408) begin
      fails++;
      $display("FAIL retake2: got %h/%b/%h want 0/1/408", level_out, interrupt_out, int_addr);
    end
    tick();
    #1;
`endif
    csr_rd(TH, d);
    tests++;
    if (d !== 32'd3 || level_out !== 4'd1) begin
      fails++;
      $display("FAIL in2: got %h/%h want 3/1", d, level_out);
    end
    pc_in = 12'hFFF;
    #1;
    tests++;
    if (int_addr !== PCN || pc_interrupt_sel !== 1'b1) begin
      fails++;
      $display("FAIL pop2: got %h/%b want %h/1", int_addr, pc_interrupt_sel, PCN);
    end
    tick();
    pc_in = PCN;
    csr_rd(TH, d);
    tests++;
    if (d !== 32'd0 || level_out !== 4'd0) begin
      fails++;
      $display("FAIL pop2_st: got %h/%h want 0/0", d, level_out);
    end
  endtask

  task automatic test_thresh();
    logic [31:0] d;
    int hits;
    csr_wr(TH, CSR_RW, 32'd2);
    csr_wr(12'hB23, CSR_RW, 32'h07);
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (interrupt_out) hits++;
      tick();
    end
    tests++;
    if (hits != 0) begin
      fails++;
      $display("FAIL below_th: got %0d takes want 0", hits);
    end
    csr_wr(TH, CSR_RW, 32'd0);
    #1;
    tests++;
    if (interrupt_out !== 1'b0) begin
      fails++;
      $display("FAIL th_lat0: got %b want 0", interrupt_out);
    end
    tick();
    #1;
    tests++;
    if (interrupt_out !== 1'b1 || int_addr !== 12'h40C) begin
      fails++;
      $display("FAIL th_take: got %b/%h want 1/40c", interrupt_out, int_addr);
    end
    tick();
    csr_rd(TH, d);
    tests++;
    if (d !== 32'd1 || level_out !== 4'd1) begin
      fails++;
      $display("FAIL th_in3: got %h/%h want 1/1", d, level_out);
    end
    pc_in = 12'hFFF;
    tick();
    pc_in = PCN;
    #1;
    tests++;
    if (level_out !== 4'd0) begin
      fails++;
      $display("FAIL th_ret: got %h want 0", level_out);
    end
  endtask

  task automatic test_ext();
    logic [31:0] d;
    int hits;
    csr_wr(12'hB21, CSR_RW, 32'h2A);
    ext_irq = 4'b0010;
    hits = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 10) ext_irq = 4'b0000;
      #1;
      if (interrupt_out) hits++;
      tick();
    end
    tests++;
    if (hits != 1 || level_out !== 4'd1) begin
      fails++;
      $display("FAIL edge_once: got %0d/%h want 1/1", hits, level_out);
    end
    pc_in = 12'hFFF;
    tick();
    pc_in = PCN;
    csr_wr(MS, CSR_RCI, 32'h8);
    csr_wr(12'hB21, CSR_RW, 32'h0A);
    ext_irq = 4'b0010;
    for (int i = 0; i < 4; i++) tick();
    csr_rd(12'hB21, d);
    tests++;
    if (d !== 32'h0B) begin
      fails++;
      $display("FAIL lvl_pend: got %h want 0b", d);
    end
    csr_wr(12'hB21, CSR_RCI, 32'h1);
    csr_rd(12'hB21, d);
    tests++;
    if (d !== 32'h0B) begin
      fails++;
      $display("FAIL lvl_repend: got %h want 0b", d);
    end
    ext_irq = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    csr_wr(12'hB21, CSR_RCI, 32'h1);
    tick();
    csr_rd(12'hB21, d);
    tests++;
    if (d !== 32'h0A) begin
      fails++;
      $display("FAIL lvl_clear: got %h want 0a", d);
    end
    csr_wr(12'hB21, CSR_RW, 32'h0);
    csr_wr(MS, CSR_RSI, 32'h8);
  endtask

  task automatic test_stack_err();
    pc_in = 12'hFFF;
    #1;
    tests++;
    if (int_addr !== 12'hFFF || pc_interrupt_sel !== 1'b0 || interrupt_out !== 1'b0) begin
      fails++;
      $display("FAIL empty_pop: got %h/%b/%b want fff/0/0", int_addr, pc_interrupt_sel, interrupt_out);
    end
    tick();
    pc_in = PCN;
    tick();
    #1;
    tests++;
    if (stack_err !== 1'b1 || level_out !== 4'd0) begin
      fails++;
      $display("FAIL err_sticky: got %b/%h want 1/0", stack_err, level_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    csr_wr(12'hB22, CSR_RW, 32'h0F);
    tick();
    #1;
    tests++;
    if (interrupt_out !== 1'b1 || int_addr !== 12'h408) begin
      fails++;
      $display("FAIL mid_take2: got %b/%h want 1/408", interrupt_out, int_addr);
    end
    tick();
    pc_in = 12'h104;
    csr_wr(12'hB26, CSR_RW, 32'h17);
    tick();
    #1;
    tests++;
    if (interrupt_out !== 1'b1 || int_addr !== 12'h418) begin
      fails++;
      $display("FAIL nest6: got %b/%h want 1/418", interrupt_out, int_addr);
    end
    tick();
    #1;
    tests++;
    if (level_out !== 4'd2) begin
      fails++;
      $display("FAIL nest_lvl: got %h want 2", level_out);
    end
    pc_in = PCN;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    csr_rd(TH, d);
    tests++;
    if (level_out !== 4'd0 || d !== 32'd0 || stack_err !== 1'b0 ||
        pc_interrupt_sel !== 1'b0 || int_addr !== PCN) begin
      fails++;
      $display("FAIL mid_rst: got %h/%h/%b/%b/%h want 0/0/0/0/%h",
               level_out, d, stack_err, pc_interrupt_sel, int_addr, PCN);
    end
    csr_rd(12'hB22, d);
    tests++;
    if (d !== 32'd0) begin
      fails++;
      $display("FAIL mid_rst_ent: got %h want 0", d);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_take();
    test_return();
    test_thresh();
    test_ext();
    test_stack_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
